// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with 2-entry skid, flush and stall counter
// Main entry drives the outputs; the skid entry absorbs one beat while downstream stalls.

module pipe_stage_skid #(
  parameter int unsigned        INSTR_W     = 32,
  parameter int unsigned        PC_W        = 32,
  parameter int unsigned        CTRL_W      = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = 'h0000_0013,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter logic [PC_W-1:0]    PC_RST      = '0,
  parameter int unsigned        STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [INSTR_W-1:0]     main_instr_q, main_instr_d;
  logic [PC_W-1:0]        main_pc_q, main_pc_d;
  logic [CTRL_W-1:0]      main_ctrl_q, main_ctrl_d;
  logic [INSTR_W-1:0]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]        skid_pc_q, skid_pc_d;
  logic [CTRL_W-1:0]      skid_ctrl_q, skid_ctrl_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic in_fire;
  logic out_fire;

  // Handshake flags come from registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_instr = main_instr_q;
  assign out_pc    = main_pc_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    main_ctrl_d  = main_ctrl_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush) begin
      // Bubbles keep their PC; only instruction and control are neutralised.
      state_d      = ST_EMPTY;
      main_instr_d = NOP_INSTR;
      main_ctrl_d  = CTRL_BUBBLE;
      skid_instr_d = NOP_INSTR;
      skid_ctrl_d  = CTRL_BUBBLE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
            main_ctrl_d  = in_ctrl;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
            main_ctrl_d  = in_ctrl;
          end else if (out_fire) begin
            main_instr_d = NOP_INSTR;
            main_ctrl_d  = CTRL_BUBBLE;
            state_d      = ST_EMPTY;
          end else if (in_fire) begin
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
            skid_ctrl_d  = in_ctrl;
            state_d      = ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_instr_d = NOP_INSTR;
            skid_ctrl_d  = CTRL_BUBBLE;
            state_d      = ST_ONE;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_instr_d = NOP_INSTR;
          main_ctrl_d  = CTRL_BUBBLE;
          skid_instr_d = NOP_INSTR;
          skid_ctrl_d  = CTRL_BUBBLE;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= PC_RST;
      main_ctrl_q  <= CTRL_BUBBLE;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= PC_RST;
      skid_ctrl_q  <= CTRL_BUBBLE;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_ctrl_q  <= skid_ctrl_d;
      stall_q      <= stall_d;
    end
  end

endmodule
